// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit for dmem, LED and cycle-counter peripherals
// Cycle counter at PERIPH_BASE+4 exists only when LSU_CYCLE_COUNTER_EN is defined.
module load_store_unit #(
    parameter int unsigned DMEM_BYTES  = 128,
    parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata,
    output logic [7:0]  led
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        code_ok, misaligned, hit_dmem, hit_led, cnt_ok, acc_err;
    logic [3:0]  lanes;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] dmem_load, load_data, cnt_value;

    assign hit_dmem = cap_addr < DMEM_BYTES;
    assign hit_led  = cap_addr == PERIPH_BASE;
    assign daddr    = cap_addr;

`ifdef LSU_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;
    logic        hit_cnt;

    assign hit_cnt   = cap_addr == PERIPH_BASE + 32'd4;
    assign cnt_ok    = hit_cnt && !cap_we && cap_f3 == 3'b010;
    assign cnt_value = cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    assign cnt_ok    = 1'b0;
    assign cnt_value = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        we         = '0;
        if (state == ACCESS && cap_we && !acc_err && hit_dmem) begin
            we = lanes;
        end
    end

    // Any rejected access (bad code, misalignment, unmapped/illegal target) becomes an error with no side effect.
    always_comb begin
        case (cap_f3)
            3'b000, 3'b001, 3'b010: code_ok = 1'b1;
            3'b100, 3'b101:         code_ok = !cap_we;
            default:                code_ok = 1'b0;
        endcase
        misaligned = (cap_f3[1:0] == 2'b01 && cap_addr[0]) ||
                     (cap_f3[1:0] == 2'b10 && cap_addr[1:0] != 2'b00);
        acc_err    = !code_ok || misaligned || !(hit_dmem || hit_led || cnt_ok);
    end

    always_comb begin
        case (cap_f3[1:0])
            2'b00: begin
                lanes  = 4'b0001 << cap_addr[1:0];
                dwdata = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                lanes  = cap_addr[1] ? 4'b1100 : 4'b0011;
                dwdata = {2{cap_wdata[15:0]}};
            end
            default: begin
                lanes  = 4'b1111;
                dwdata = cap_wdata;
            end
        endcase
    end

    always_comb begin
        case (cap_addr[1:0])
            2'b00:   byte_sel = drdata[7:0];
            2'b01:   byte_sel = drdata[15:8];
            2'b10:   byte_sel = drdata[23:16];
            default: byte_sel = drdata[31:24];
        endcase
        half_sel = cap_addr[1] ? drdata[31:16] : drdata[15:0];
        case (cap_f3)
            3'b000:  dmem_load = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  dmem_load = {{16{half_sel[15]}}, half_sel};
            3'b100:  dmem_load = {24'b0, byte_sel};
            3'b101:  dmem_load = {16'b0, half_sel};
            default: dmem_load = drdata;
        endcase
        if (hit_dmem) begin
            load_data = dmem_load;
        end else if (hit_led) begin
            load_data = {24'b0, led};
        end else begin
            load_data = cnt_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_we     <= 1'b0;
            cap_f3     <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            led        <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_we    <= req_we;
                cap_f3    <= req_funct3;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (state == ACCESS) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
                if (cap_we && !acc_err && hit_led) begin
                    led <= cap_wdata[7:0];
                end
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 128, dmem size in bytes (dmem region 0x0..DMEM_BYTES-1).
REQ-002 SHALL have parameter PERIPH_BASE, default 32'h8000_0000, base of peripheral region.
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have CPU request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_funct3 in 3; req_addr in 32; req_wdata in 32.
REQ-006 SHALL have CPU response ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32; resp_err out 1.
REQ-007 SHALL have dmem ports: daddr out 32; dwdata out 32; we out 4 (byte lane enables); drdata in 32 (combinational read).
REQ-008 SHALL have port led, output, 8, memory-mapped LED register.

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-010 SHALL capture we/funct3/addr/wdata on req_valid&&req_ready and move to ACCESS.
REQ-011 ACCESS SHALL last exactly one cycle; response registered into RESP; resp_valid asserted 2 cycles after acceptance.
REQ-012 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then return to IDLE; request accepted in the same cycle impossible (req_ready=0).
REQ-013 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; any other code -> resp_err=1, no side effect.
REQ-014 Misalignment (halfword addr[0]=1, word addr[1:0]!=0) SHALL give resp_err=1, we=0, no peripheral write.
REQ-015 Address map: dmem if addr<DMEM_BYTES; LED at PERIPH_BASE+0 (RW); cycle counter at PERIPH_BASE+4 (RO, word access only); else resp_err=1.
REQ-016 daddr SHALL equal captured address; we SHALL be non-zero only in ACCESS for a valid dmem store.
REQ-017 Store lanes: SB we=1<<addr[1:0], byte replicated on all lanes; SH we=0011 (addr[1]=0) or 1100, halfword replicated; SW we=1111, dwdata=wdata.
REQ-018 Load data SHALL be lane-selected from drdata by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU), sampled in ACCESS.
REQ-019 Store to LED (any valid width) SHALL write led<=wdata[7:0] in ACCESS; LED load returns {24'b0,led}.
REQ-020 Store to counter SHALL give resp_err=1; non-word load of counter SHALL give resp_err=1.
REQ-021 Counter SHALL increment every cycle, wrap 0xFFFF_FFFF->0; a read returns its value in the ACCESS cycle.
REQ-022 Store responses SHALL return resp_rdata=0; error responses SHALL return resp_rdata=0.

Reset
REQ-023 reset SHALL force IDLE immediately: req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, we=0, dwdata=0, daddr=0, led=0, counter=0.
REQ-024 reset during ACCESS or RESP SHALL abort the transaction with no dmem or LED write and no response.

Configuration
REQ-025 Macro LSU_CYCLE_COUNTER_EN: defined -> counter implemented per REQ-021; undefined -> no counter logic, any access to PERIPH_BASE+4 gives resp_err=1.

Verification
REQ-026 SW 0x11223344 to 0x10, then LW 0x10 -> we=1111 in ACCESS; rdata=0x11223344, err=0, resp_valid 2 cycles after accept.
REQ-027 SB 0xAB to 0x13, then LB 0x13 and LBU 0x13 -> we=1000; LB rdata=0xFFFFFFAB, LBU rdata=0x000000AB.
REQ-028 LH 0x11 and SW 0x12 -> both resp_err=1, we stays 0000, memory unchanged.
REQ-029 SW 0x5A to 0x80000000, LW 0x80000000 -> led=0x5A, rdata=0x0000005A; LW 0x80000004 twice, 10 cycles apart -> difference 10 (err=1 when LSU_CYCLE_COUNTER_EN undefined).
REQ-030 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0; reset asserted in ACCESS of SW to 0x20 -> no write, IDLE after release.
